// File: rtl/sys_bus.sv
// -----------------------------------------------------------------------------
// sys_bus -- single-master to NS-slave bus bridge.
//
// The master issues one transaction at a time (m_req held until m_ack). The
// top SELW address bits select a slave. A mapped access raises that slave's
// s_req until it acks or a wait counter runs out (TMO); an unmapped access is
// answered immediately with an error. Every transaction ends with a one-cycle
// m_ack; m_rdata/m_err are registered and held until the next response.
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous active-high reset
//   m_req    in   1      master request, held until m_ack
//   m_we     in   1      master write enable (1 = write)
//   m_addr   in   AW     master address (sel = m_addr[AW-1:AW-SELW])
//   m_wdata  in   DW     master write data
//   m_rdata  out  DW     read data, valid with m_ack, held afterwards
//   m_ack    out  1      one-cycle completion pulse
//   m_err    out  1      error flag (unmapped or timeout), valid with m_ack
//   s_req    out  NS     one-hot slave request, high in BUSY only
//   s_we     out  1      latched write enable, shared
//   s_addr   out  AW     latched address, shared
//   s_wdata  out  DW     latched write data, shared
//   s_rdata  in   NS*DW  slave read data, slave i at [i*DW +: DW]
//   s_ack    in   NS     per-slave acknowledge
// -----------------------------------------------------------------------------
module sys_bus #(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int NS   = 4,
  parameter int SELW = 2,
  parameter int TMO  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_req,
  input  logic             m_we,
  input  logic [AW-1:0]    m_addr,
  input  logic [DW-1:0]    m_wdata,
  output logic [DW-1:0]    m_rdata,
  output logic             m_ack,
  output logic             m_err,
  output logic [NS-1:0]    s_req,
  output logic             s_we,
  output logic [AW-1:0]    s_addr,
  output logic [DW-1:0]    s_wdata,
  input  logic [NS*DW-1:0] s_rdata,
  input  logic [NS-1:0]    s_ack
);

  localparam int CW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SELW-1:0] sel_in, sel_q;
  logic            mapped_in;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic [CW-1:0]   cnt_q;

  logic            ack_sel;
  logic [DW-1:0]   rdata_sel;
  logic            tmo_hit;
  logic            accept;
  logic            done_ok;
  logic            done_err;

  assign sel_in  = m_addr[AW-1:AW-SELW];
  assign tmo_hit = (cnt_q == CW'(TMO));

  // Decode the select field against the populated slaves and pick out the
  // selected slave's ack/data. Written as loops so that no index ever points
  // past NS when fewer slaves than 2**SELW are populated.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    mapped_in = 1'b0;
    ack_sel   = 1'b0;
    rdata_sel = '0;
    s_req     = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel_in == SELW'(i)) mapped_in = 1'b1;
      if (sel_q == SELW'(i)) begin
        ack_sel   = s_ack[i];
        rdata_sel = s_rdata[i*DW +: DW];
        s_req[i]  = (state == BUSY);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and transaction-event decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    unique case (state)
      IDLE: begin
        if (m_req) begin
          accept = 1'b1;
          if (mapped_in) begin
            state_nxt = BUSY;
          end else begin
            state_nxt = RESP;
            done_err  = 1'b1;
          end
        end
      end
      BUSY: begin
        // The ack is tested before the counter so an ack on the last
        // allowed cycle still completes without error.
        if (ack_sel) begin
          state_nxt = RESP;
          done_ok   = 1'b1;
        end else if (tmo_hit) begin
          state_nxt = RESP;
          done_err  = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Transaction latches, wait counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        sel_q   <= sel_in;
        we_q    <= m_we;
        addr_q  <= m_addr;
        wdata_q <= m_wdata;
        cnt_q   <= '0;
      end else if (state == BUSY && !ack_sel && !tmo_hit) begin
        cnt_q <= cnt_q + CW'(1);
      end

      if (done_ok) begin
        rdata_q <= we_q ? '0 : rdata_sel;
        err_q   <= 1'b0;
      end else if (done_err) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign m_ack   = (state == RESP);
  assign m_rdata = rdata_q;
  assign m_err   = err_q;
  assign s_we    = we_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;

endmodule

// File: tb/tb_sys_bus.sv
// -----------------------------------------------------------------------------
// tb_sys_bus -- directed bench for sys_bus.
//
// Main DUT: NS=4, TMO=15. A second instance with NS=3 exercises the unmapped
// path. A transaction-level model tracks, per transaction, which slave is
// addressed, the cycle index of the response and the expected result; a
// negedge process compares every DUT output against it each cycle.
// -----------------------------------------------------------------------------
module tb_sys_bus;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NS  = 4;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m_req = 1'b0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata;
  logic          m_ack;
  logic          m_err;
  logic [NS-1:0] s_req;
  logic          s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [NS*DW-1:0] s_rdata = '0;
  logic [NS-1:0] s_ack = '0;

  // NS=3 instance
  logic          m_req3 = 1'b0;
  logic [DW-1:0] m_rdata3;
  logic          m_ack3;
  logic          m_err3;
  logic [2:0]    s_req3;
  logic          s_we3;
  logic [AW-1:0] s_addr3;
  logic [DW-1:0] s_wdata3;
  logic [3*DW-1:0] s_rdata3 = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
  logic [2:0]    s_ack3 = '0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sys_bus #(.DW(DW), .AW(AW), .NS(NS), .SELW(2), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  sys_bus #(.DW(DW), .AW(AW), .NS(3), .SELW(2), .TMO(TMO)) dut3 (
    .clk(clk), .rst(rst),
    .m_req(m_req3), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata3), .m_ack(m_ack3), .m_err(m_err3),
    .s_req(s_req3), .s_we(s_we3), .s_addr(s_addr3), .s_wdata(s_wdata3),
    .s_rdata(s_rdata3), .s_ack(s_ack3)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level model. mdl_k counts cycles since the accepting edge;
  // cycles 0..mdl_r-1 are the slave-wait cycles, cycle mdl_r is the response.
  // ---------------------------------------------------------------------------
  bit            mdl_active = 1'b0;
  bit            mdl_mapped = 1'b0;
  int            mdl_k = -1;
  int            mdl_r = 0;
  int            mdl_sel = 0;
  logic          mdl_we = 1'b0;
  logic [AW-1:0] mdl_addr = '0;
  logic [DW-1:0] mdl_wdata = '0;
  logic [DW-1:0] mdl_rdata = '0;
  logic          mdl_err = 1'b0;
  logic          mdl_lat_we = 1'b0;
  logic [AW-1:0] mdl_lat_addr = '0;
  logic [DW-1:0] mdl_lat_wdata = '0;
  logic [DW-1:0] mdl_last_rdata = '0;
  logic          mdl_last_err = 1'b0;

  task automatic model_reset();
    mdl_active     = 1'b0;
    mdl_k          = -1;
    mdl_lat_we     = 1'b0;
    mdl_lat_addr   = '0;
    mdl_lat_wdata  = '0;
    mdl_last_rdata = '0;
    mdl_last_err   = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [NS-1:0] exp_sreq;
    exp_sreq = '0;
    if (mdl_active && mdl_mapped && mdl_k >= 0 && mdl_k < mdl_r) exp_sreq[mdl_sel] = 1'b1;
    check("s_req",   64'(s_req),   64'(exp_sreq));
    check("m_ack",   64'(m_ack),   64'(mdl_active && mdl_k == mdl_r));
    check("m_rdata", 64'(m_rdata), 64'(mdl_last_rdata));
    check("m_err",   64'(m_err),   64'(mdl_last_err));
    check("s_we",    64'(s_we),    64'(mdl_lat_we));
    check("s_addr",  64'(s_addr),  64'(mdl_lat_addr));
    check("s_wdata", 64'(s_wdata), 64'(mdl_lat_wdata));
    check("s_req3",  64'(s_req3),  64'(0));
  end

  // Runs one transaction on the main DUT. ack_idx is the wait-cycle index on
  // which the addressed slave acks (-1 = never). noise adds acks from other
  // slaves and changes the master inputs during the wait. abort_at >= 0
  // asserts rst in that wait cycle.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int ack_idx, input logic [DW-1:0] rd, input bit noise,
                         input int abort_at, output int ack_k,
                         output logic [DW-1:0] cap_rdata, output logic cap_err);
    int  sel;
    bit  late;
    bit  aborted;
    sel     = int'(addr[AW-1:AW-2]);
    late    = (ack_idx < 0) || (ack_idx > TMO);
    aborted = 1'b0;

    mdl_sel    = sel;
    mdl_mapped = (sel < NS);
    mdl_r      = !mdl_mapped ? 0 : ((late ? TMO : ack_idx) + 1);
    mdl_err    = !mdl_mapped || late;
    mdl_rdata  = (mdl_err || we) ? '0 : rd;
    mdl_we     = we;
    mdl_addr   = addr;
    mdl_wdata  = wdata;
    mdl_k      = -1;
    mdl_active = 1'b1;

    ack_k     = -1;
    cap_rdata = '0;
    cap_err   = 1'b0;

    m_req   = 1'b1;
    m_we    = we;
    m_addr  = addr;
    m_wdata = wdata;
    s_ack   = '0;
    for (int i = 0; i < NS; i++)
      s_rdata[i*DW +: DW] = (i == sel) ? rd : DW'($urandom);

    for (int k = 0; k <= mdl_r; k++) begin
      @(posedge clk); #1;
      mdl_k = k;
      if (k == 0) begin
        mdl_lat_we    = mdl_we;
        mdl_lat_addr  = mdl_addr;
        mdl_lat_wdata = mdl_wdata;
      end
      if (k == mdl_r) begin
        mdl_last_rdata = mdl_rdata;
        mdl_last_err   = mdl_err;
      end
      if (m_ack === 1'b1 && ack_k < 0) begin
        ack_k     = k;
        cap_rdata = m_rdata;
        cap_err   = m_err;
      end
      s_ack = noise ? NS'($urandom) : '0;
      if (k < mdl_r) s_ack[sel] = (k == ack_idx);
      if (noise) begin
        m_addr  = AW'($urandom);
        m_wdata = DW'($urandom);
        m_we    = ~m_we;
      end
      if (k == abort_at) begin
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_s_req",  64'(s_req),  64'(0));
        check("rst_m_ack",  64'(m_ack),  64'(0));
        check("rst_s_addr", 64'(s_addr), 64'(0));
        aborted = 1'b1;
        break;
      end
    end

    @(posedge clk); #1;
    if (aborted) rst = 1'b0;
    mdl_active = 1'b0;
    m_req      = 1'b0;
    s_ack      = '0;
  endtask

  initial begin
    int            ak;
    logic [DW-1:0] rdv;
    logic          erv;

    // Reset state, still in reset.
    repeat (2) @(posedge clk);
    #1;
    check("reset_s_req",   64'(s_req),   64'(0));
    check("reset_m_ack",   64'(m_ack),   64'(0));
    check("reset_m_err",   64'(m_err),   64'(0));
    check("reset_m_rdata", 64'(m_rdata), 64'(0));
    check("reset_s_we",    64'(s_we),    64'(0));
    check("reset_s_addr",  64'(s_addr),  64'(0));
    check("reset_s_wdata", 64'(s_wdata), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Read slave 1, ack in first wait cycle.
    run_txn(1'b0, 32'h4000_0010, 32'h0, 0, 32'h1234_5678, 1'b0, -1, ak, rdv, erv);
    check("rd1_latency", 64'(ak),  64'(1));
    check("rd1_rdata",   64'(rdv), 64'h1234_5678);
    check("rd1_err",     64'(erv), 64'(0));

    // Write slave 0, ack after 3 wait cycles; writes return zero data.
    run_txn(1'b1, 32'h0000_0004, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF, 1'b0, -1, ak, rdv, erv);
    check("wr0_latency", 64'(ak),  64'(4));
    check("wr0_rdata",   64'(rdv), 64'(0));
    check("wr0_err",     64'(erv), 64'(0));

    // Unmapped access on the NS=3 instance; stray acks must be ignored.
    m_addr = 32'hC000_0000;
    m_we   = 1'b0;
    m_req3 = 1'b1;
    s_ack3 = 3'b111;
    @(posedge clk); #1;
    check("unm_ack",   64'(m_ack3),   64'(1));
    check("unm_err",   64'(m_err3),   64'(1));
    check("unm_rdata", 64'(m_rdata3), 64'(0));
    check("unm_s_req", 64'(s_req3),   64'(0));
    @(posedge clk); #1;
    m_req3 = 1'b0;
    s_ack3 = '0;
    check("unm_ack_one_cycle", 64'(m_ack3), 64'(0));
    check("unm_err_held",      64'(m_err3), 64'(1));
    @(posedge clk); #1;

    // Slave 2 never acks: timeout.
    run_txn(1'b0, 32'h8000_0100, 32'h0, -1, 32'h5555_AAAA, 1'b0, -1, ak, rdv, erv);
    check("tmo_latency", 64'(ak),  64'(TMO + 1));
    check("tmo_rdata",   64'(rdv), 64'(0));
    check("tmo_err",     64'(erv), 64'(1));

    // Slave 2 acks on the final counter cycle: ack wins.
    run_txn(1'b0, 32'h8000_0200, 32'h0, TMO, 32'h0BAD_CAFE, 1'b0, -1, ak, rdv, erv);
    check("ackfirst_latency", 64'(ak),  64'(TMO + 1));
    check("ackfirst_rdata",   64'(rdv), 64'h0BAD_CAFE);
    check("ackfirst_err",     64'(erv), 64'(0));

    // Slave 0 selected while other slaves ack and master inputs churn.
    run_txn(1'b0, 32'h0000_0ABC, 32'h0, 5, 32'h7777_1111, 1'b1, -1, ak, rdv, erv);
    check("noise_latency", 64'(ak),  64'(6));
    check("noise_rdata",   64'(rdv), 64'h7777_1111);
    check("noise_err",     64'(erv), 64'(0));

    // Reset during the wait on slave 1; no ack must follow.
    run_txn(1'b0, 32'h4000_0020, 32'h0, 5, 32'h9999_0000, 1'b0, 2, ak, rdv, erv);
    check("abort_no_ack", 64'(ak), 64'hFFFF_FFFF_FFFF_FFFF);

    // Read slave 3 immediately after reset release.
    run_txn(1'b0, 32'hC000_0040, 32'h0, 0, 32'h3333_3333, 1'b0, -1, ak, rdv, erv);
    check("rd3_latency", 64'(ak),  64'(1));
    check("rd3_rdata",   64'(rdv), 64'h3333_3333);
    check("rd3_err",     64'(erv), 64'(0));

    // Write slave 3 with noise.
    run_txn(1'b1, 32'hC000_0080, 32'hA5A5_5A5A, 2, 32'h4444_4444, 1'b1, -1, ak, rdv, erv);
    check("wr3_latency", 64'(ak),  64'(3));
    check("wr3_rdata",   64'(rdv), 64'(0));
    check("wr3_err",     64'(erv), 64'(0));

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
